// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode encodings and default sizing shared by the ALU files.
// Revision    : 1.0
// ============================================================================
package alu_pkg;

    localparam int c_DEFAULT_WIDTH = 8;
    localparam int c_DEFAULT_DEPTH = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } opcode_e;

endpackage
`default_nettype wire

// File: rtl/alu_datapath.sv
`default_nettype none
// ============================================================================
// Module      : alu_datapath
// Description : Combinational ALU core producing next result and status flags.
// Revision    : 1.0
// ============================================================================
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int DEPTH = c_DEFAULT_DEPTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [DEPTH-1:0] i_opcode,
    output logic [WIDTH-1:0] o_y,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero
);

    localparam int c_MSB = WIDTH - 1;

    logic             w_op_valid;
    opcode_e          w_op;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_y;
    logic             w_carry;
    logic             w_overflow;

    // Codes beyond the 3-bit map only exist when the opcode is wider than 3 bits.
    generate
        if (DEPTH > 3) begin : g_wide_opcode
            assign w_op_valid = (i_opcode[DEPTH-1:3] == '0);
        end else begin : g_narrow_opcode
            assign w_op_valid = 1'b1;
        end
    endgenerate

    assign w_op   = opcode_e'(i_opcode[2:0]);
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    // The extra top bit of the widened difference is the unsigned borrow.
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        w_y        = '0;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        if (w_op_valid) begin
            case (w_op)
                OP_ADD: begin
                    w_y        = w_sum[WIDTH-1:0];
                    w_carry    = w_sum[WIDTH];
                    w_overflow = (i_a[c_MSB] == i_b[c_MSB]) && (w_sum[c_MSB] != i_a[c_MSB]);
                end
                OP_SUB: begin
                    w_y        = w_diff[WIDTH-1:0];
                    w_carry    = w_diff[WIDTH];
                    w_overflow = (i_a[c_MSB] != i_b[c_MSB]) && (w_diff[c_MSB] != i_a[c_MSB]);
                end
                OP_AND: w_y = i_a & i_b;
                OP_OR:  w_y = i_a | i_b;
                OP_XOR: w_y = i_a ^ i_b;
                OP_NOT: w_y = ~i_a;
                OP_SHL: begin
                    w_y     = {i_a[WIDTH-2:0], 1'b0};
                    w_carry = i_a[c_MSB];
                end
                OP_SHR: begin
                    w_y     = {1'b0, i_a[WIDTH-1:1]};
                    w_carry = i_a[0];
                end
                default: ;
            endcase
        end
    end

    assign o_y        = w_y;
    assign o_carry    = w_carry;
    assign o_overflow = w_overflow;
    assign o_zero     = (w_y == '0);

endmodule
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Registered ALU, one-cycle latency, one operation per clock.
// Revision    : 1.0
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int DEPTH = c_DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [DEPTH-1:0] opcode,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             zero,
    output logic             overflow
);

    logic [WIDTH-1:0] w_y;
    logic             w_carry;
    logic             w_overflow;
    logic             w_zero;

    logic [WIDTH-1:0] r_y;
    logic             r_carry;
    logic             r_overflow;
    logic             r_zero;

    alu_datapath #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_datapath (
        .i_a        (operand_a),
        .i_b        (operand_b),
        .i_opcode   (opcode),
        .o_y        (w_y),
        .o_carry    (w_carry),
        .o_overflow (w_overflow),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y        <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b1;
        end else begin
            r_y        <= w_y;
            r_carry    <= w_carry;
            r_overflow <= w_overflow;
            r_zero     <= w_zero;
        end
    end

    assign y        = r_y;
    assign carry    = r_carry;
    assign zero     = r_zero;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu
// Description : Scoreboard testbench for the registered ALU.
// Revision    : 1.0
// ============================================================================
module tb_alu;
    import alu_pkg::*;

    typedef struct packed {
        logic [7:0] y;
        logic       c;
        logic       z;
        logic       v;
    } exp_t;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic [2:0] opcode;
    logic [3:0] opcode4;
    logic [7:0] y,  y4;
    logic       carry, zero, overflow;
    logic       carry4, zero4, overflow4;

    exp_t sb[$];
    exp_t sb4[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    alu #(.WIDTH(8), .DEPTH(3)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .opcode    (opcode),
        .y         (y),
        .carry     (carry),
        .zero      (zero),
        .overflow  (overflow)
    );

    alu #(.WIDTH(8), .DEPTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .opcode    (opcode4),
        .y         (y4),
        .carry     (carry4),
        .zero      (zero4),
        .overflow  (overflow4)
    );

    // Reference model written in integer arithmetic.
    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   r, sa, sbv;
        e   = '0;
        sa  = $signed(a);
        sbv = $signed(b);
        case (op)
            3'd0: begin
                r = int'(a) + int'(b);
                e.y = r[7:0];
                e.c = (r > 255);
                e.v = ((sa + sbv) > 127) || ((sa + sbv) < -128);
            end
            3'd1: begin
                r = int'(a) - int'(b);
                e.y = r[7:0];
                e.c = (a < b);
                e.v = ((sa - sbv) > 127) || ((sa - sbv) < -128);
            end
            3'd2: e.y = a & b;
            3'd3: e.y = a | b;
            3'd4: e.y = a ^ b;
            3'd5: e.y = ~a;
            3'd6: begin
                r = int'(a) * 2;
                e.y = r[7:0];
                e.c = (a >= 8'h80);
            end
            default: begin
                e.y = a / 8'd2;
                e.c = ((a % 8'd2) == 8'd1);
            end
        endcase
        e.z = (e.y == 8'h00);
        return e;
    endfunction

    task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input exp_t e);
        opcode    = op;
        operand_a = a;
        operand_b = b;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(OP_ADD, 8'hFF, 8'h01, {8'h00, 1'b0, 1'b1, 1'b0});
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL reset: scoreboard empty");
            end else begin
                e = sb.pop_front();
                n_checks++;
                if ({y, carry, zero, overflow} !== e) begin
                    n_fail++;
                    $display("FAIL reset[%0d]: got y=%h c=%b z=%b v=%b, expected y=%h c=%b z=%b v=%b",
                             i, y, carry, zero, overflow, e.y, e.c, e.z, e.v);
                end
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_arith();
        vec_t tbl[5];
        exp_t e;
        tbl[0] = {OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[1] = {OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
        tbl[2] = {OP_SUB, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0};
        tbl[3] = {OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1};
        tbl[4] = {OP_SUB, 8'h55, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL arith: scoreboard empty");
            end else begin
                e = sb.pop_front();
                n_checks++;
                if ({y, carry, zero, overflow} !== e) begin
                    n_fail++;
                    $display("FAIL arith[%0d]: got y=%h c=%b z=%b v=%b, expected y=%h c=%b z=%b v=%b",
                             i, y, carry, zero, overflow, e.y, e.c, e.z, e.v);
                end
            end
        end
    endtask

    task automatic test_logic();
        vec_t tbl[4];
        exp_t e;
        tbl[0] = {OP_AND, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[1] = {OP_OR,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[2] = {OP_XOR, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[3] = {OP_NOT, 8'h00, 8'h5A, 8'hFF, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL logic: scoreboard empty");
            end else begin
                e = sb.pop_front();
                n_checks++;
                if ({y, carry, zero, overflow} !== e) begin
                    n_fail++;
                    $display("FAIL logic[%0d]: got y=%h c=%b z=%b v=%b, expected y=%h c=%b z=%b v=%b",
                             i, y, carry, zero, overflow, e.y, e.c, e.z, e.v);
                end
            end
        end
    endtask

    task automatic test_shift();
        vec_t tbl[3];
        exp_t e;
        tbl[0] = {OP_SHL, 8'h81, 8'h33, 8'h02, 1'b1, 1'b0, 1'b0};
        tbl[1] = {OP_SHR, 8'h01, 8'h33, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[2] = {OP_SHR, 8'h80, 8'h33, 8'h40, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL shift: scoreboard empty");
            end else begin
                e = sb.pop_front();
                n_checks++;
                if ({y, carry, zero, overflow} !== e) begin
                    n_fail++;
                    $display("FAIL shift[%0d]: got y=%h c=%b z=%b v=%b, expected y=%h c=%b z=%b v=%b",
                             i, y, carry, zero, overflow, e.y, e.c, e.z, e.v);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        logic [2:0] op;
        logic [7:0] a, b;
        for (int i = 0; i < 24; i++) begin
            op = (i < 8) ? 3'(i) : 3'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = 8'($urandom);
            drive(op, a, b, model(op, a, b));
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL b2b: scoreboard empty");
            end else begin
                e = sb.pop_front();
                n_checks++;
                if ({y, carry, zero, overflow} !== e) begin
                    n_fail++;
                    $display("FAIL b2b[%0d] op=%0d a=%h b=%h: got y=%h c=%b z=%b v=%b, expected y=%h c=%b z=%b v=%b",
                             i, op, a, b, y, carry, zero, overflow, e.y, e.c, e.z, e.v);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        vec_t tbl[6];
        logic rst_tbl[6];
        exp_t e;
        tbl[0] = {OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1};
        tbl[1] = {OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[2] = {OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[3] = {OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[4] = {OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
        tbl[5] = {OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
        rst_tbl = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            rst_n = rst_tbl[i];
            drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL rst_mid: scoreboard empty");
            end else begin
                e = sb.pop_front();
                n_checks++;
                if ({y, carry, zero, overflow} !== e) begin
                    n_fail++;
                    $display("FAIL rst_mid[%0d]: got y=%h c=%b z=%b v=%b, expected y=%h c=%b z=%b v=%b",
                             i, y, carry, zero, overflow, e.y, e.c, e.z, e.v);
                end
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_undefined_op();
        logic [3:0] ops[4];
        logic [7:0] as[4];
        exp_t       exps[4];
        exp_t       e;
        ops  = '{4'b1000, 4'b1110, 4'b0110, 4'b0000};
        as   = '{8'hFF, 8'h81, 8'h81, 8'h7F};
        exps = '{{8'h00, 1'b0, 1'b1, 1'b0}, {8'h00, 1'b0, 1'b1, 1'b0},
                 {8'h02, 1'b1, 1'b0, 1'b0}, {8'h80, 1'b0, 1'b0, 1'b1}};
        opcode = OP_AND;
        for (int i = 0; i < 4; i++) begin
            opcode4   = ops[i];
            operand_a = as[i];
            operand_b = 8'h01;
            sb4.push_back(exps[i]);
            @(posedge clk); #1;
            if (sb4.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL undef_op: scoreboard empty");
            end else begin
                e = sb4.pop_front();
                n_checks++;
                if ({y4, carry4, zero4, overflow4} !== e) begin
                    n_fail++;
                    $display("FAIL undef_op[%0d] op=%b: got y=%h c=%b z=%b v=%b, expected y=%h c=%b z=%b v=%b",
                             i, ops[i], y4, carry4, zero4, overflow4, e.y, e.c, e.z, e.v);
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        operand_a = '0;
        operand_b = '0;
        opcode    = '0;
        opcode4   = '0;
        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_back_to_back();
        test_reset_midstream();
        test_undefined_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
